// File: rtl/match_gap_logger.sv
// match_gap_logger
//
// Counts match pulses from the pattern detector, times the gap in clock
// cycles between consecutive pulses, and queues those gaps in a small
// show-ahead FIFO that host logic drains with a pop strobe.
//
// Parameters:
//   CNT_W  width of the saturating match counter
//   GAP_W  width of the gap timer and of each FIFO entry
//   DEPTH  FIFO depth in entries (power of two, >= 2)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   y_in       match pulse, sampled every rising edge
//   clear      synchronous clear, same effect as rst, wins over y_in/rd_en
//   rd_en      pop request for the FIFO head (ignored while empty)
//   match_cnt  saturating number of matches since reset/clear
//   gap_data   FIFO head entry, forced to 0 while empty
//   gap_valid  FIFO not empty
//   fifo_full  FIFO holds DEPTH entries
//   overflow   sticky: a gap was dropped because the FIFO was full

module match_gap_logger #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             clear,
    input  logic             rd_en,
    output logic [CNT_W-1:0] match_cnt,
    output logic [GAP_W-1:0] gap_data,
    output logic             gap_valid,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]    OCC_ONE  = CW'(1);
    localparam logic [CW-1:0]    OCC_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSat
    } state_e;

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic               overflow_q, overflow_d;
    logic [GAP_W-1:0]   mem_q [DEPTH];

    logic               push;
    logic [GAP_W-1:0]   push_val;
    logic               pop;
    logic               full;
    logic               wr_en;

    // Gap-timer FSM: the timer holds the number of edges since the last
    // pulse, so its value at the next pulse is exactly the gap.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        push     = 1'b0;
        push_val = timer_q;
        unique case (state_q)
            StIdle: begin
                if (y_in) begin
                    timer_d = GAP_ONE;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (y_in) begin
                    push    = 1'b1;
                    timer_d = GAP_ONE;
                end else begin
                    if (timer_q != GAP_MAX) begin
                        timer_d = timer_q + GAP_ONE;
                    end
                    if (timer_d == GAP_MAX) begin
                        state_d = StSat;
                    end
                end
            end
            StSat: begin
                timer_d = GAP_MAX;
                if (y_in) begin
                    push     = 1'b1;
                    push_val = GAP_MAX;
                    timer_d  = GAP_ONE;
                    state_d  = StRun;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Match counter, FIFO bookkeeping and clear override.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (y_in && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
        end

        full  = (occ_q == OCC_FULL);
        pop   = rd_en && (occ_q != '0);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        wr_en = push && (!full || pop);

        wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q || (push && full && !pop);

        occ_d = occ_q;
        unique case ({wr_en, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        if (clear) begin
            match_cnt_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            overflow_d  = 1'b0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            match_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            match_cnt_q <= match_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_val;
        end
    end

    assign match_cnt = match_cnt_q;
    assign gap_valid = (occ_q != '0);
    assign gap_data  = gap_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_full = full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_match_gap_logger.sv
module tb_match_gap_logger;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             y_in;
    logic             clear;
    logic             rd_en;
    logic [CNT_W-1:0] match_cnt;
    logic [GAP_W-1:0] gap_data;
    logic             gap_valid;
    logic             fifo_full;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    match_gap_logger #(
        .CNT_W(CNT_W),
        .GAP_W(GAP_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y_in),
        .clear    (clear),
        .rd_en    (rd_en),
        .match_cnt(match_cnt),
        .gap_data (gap_data),
        .gap_valid(gap_valid),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge with the given inputs, then sample 1 time unit later.
    task automatic tick(input logic y, input logic rd, input logic clr);
        y_in  = y;
        rd_en = rd;
        clear = clr;
        @(posedge clk);
        #1;
        y_in  = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse();
        tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop();
        tick(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        y_in  = 1'b0;
        clear = 1'b0;
        rd_en = 1'b0;

        // Reset state before any edge.
        #1;
        check("rst_cnt",   match_cnt, 0);
        check("rst_valid", gap_valid, 0);
        check("rst_data",  gap_data,  0);
        check("rst_full",  fifo_full, 0);
        check("rst_ovf",   overflow,  0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Basic gaps: pulses 3 then 7 edges apart.
        pulse();
        check("basic_first_valid", gap_valid, 0);
        check("basic_first_cnt",   match_cnt, 1);
        idle(2);
        pulse();
        check("basic_g1_valid", gap_valid, 1);
        check("basic_g1_data",  gap_data,  3);
        idle(6);
        pulse();
        check("basic_cnt", match_cnt, 3);
        check("basic_head_still_3", gap_data, 3);
        pop();
        check("basic_pop1_data",  gap_data,  7);
        check("basic_pop1_valid", gap_valid, 1);
        pop();
        check("basic_pop2_valid", gap_valid, 0);
        pop();
        check("basic_pop_empty_valid", gap_valid, 0);

        // Async reset with two entries buffered (RUN continues from last pulse).
        idle(2);
        pulse();
        idle(2);
        pulse();
        check("ar_valid_pre", gap_valid, 1);
        check("ar_cnt_pre",   match_cnt, 5);
        #3;
        rst = 1'b1;
        #1;
        check("ar_cnt",   match_cnt, 0);
        check("ar_valid", gap_valid, 0);
        check("ar_data",  gap_data,  0);
        check("ar_full",  fifo_full, 0);
        check("ar_ovf",   overflow,  0);
        #1;
        rst = 1'b0;
        pulse();
        check("ar_after_cnt",   match_cnt, 1);
        check("ar_after_valid", gap_valid, 0);

        // Gap saturation: 300 edges -> 255, then 4.
        idle(299);
        pulse();
        check("sat_valid", gap_valid, 1);
        check("sat_data",  gap_data,  255);
        idle(3);
        pulse();
        pop();
        check("sat_next_data", gap_data, 4);
        pop();
        check("sat_empty", gap_valid, 0);

        // Overflow: 6 pulses 3 apart, no reads.
        tick(1'b0, 1'b0, 1'b1);
        check("clr_cnt", match_cnt, 0);
        pulse();
        for (int i = 0; i < 4; i++) begin
            idle(2);
            pulse();
        end
        check("ovf_full_at4", fifo_full, 1);
        check("ovf_not_yet",  overflow,  0);
        idle(2);
        pulse();
        check("ovf_full",  fifo_full, 1);
        check("ovf_set",   overflow,  1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_entry", gap_data, 3);
            pop();
        end
        check("ovf_drained", gap_valid, 0);
        check("ovf_sticky",  overflow,  1);

        // Push and pop on the same edge while full.
        tick(1'b0, 1'b0, 1'b1);
        check("clr_ovf", overflow, 0);
        pulse();
        for (int i = 0; i < 4; i++) begin
            idle(2);
            pulse();
        end
        idle(4);
        tick(1'b1, 1'b1, 1'b0);
        check("pp_full", fifo_full, 1);
        check("pp_ovf",  overflow,  0);
        check("pp_head", gap_data,  3);
        pop();
        pop();
        check("pp_third", gap_data, 3);
        pop();
        check("pp_last", gap_data, 5);
        pop();
        check("pp_empty", gap_valid, 0);

        // Clear coincident with a pulse: pulse lost, FSM back to IDLE.
        tick(1'b1, 1'b0, 1'b1);
        check("cp_cnt",   match_cnt, 0);
        check("cp_valid", gap_valid, 0);
        idle(2);
        pulse();
        check("cp_first_valid", gap_valid, 0);
        check("cp_first_cnt",   match_cnt, 1);
        idle(3);
        pulse();
        check("cp_gap_valid", gap_valid, 1);
        check("cp_gap_data",  gap_data,  4);
        check("cp_gap_cnt",   match_cnt, 2);

        // Count saturation with back-to-back pulses (gap of 1).
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) pulse();
        check("cs_cnt15",  match_cnt, 15);
        check("cs_gap1",   gap_data,  1);
        for (int i = 0; i < 5; i++) pulse();
        check("cs_hold",   match_cnt, 15);
        check("cs_ovf",    overflow,  1);
        pop();
        check("cs_pop_gap1", gap_data, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_gap_logger.md
# match_gap_logger

Downstream consumer of the serial pattern detector's registered match pulse `y`. It counts matches, measures the clock-cycle gap between consecutive matches, and buffers those gaps in a small show-ahead FIFO. Host logic reads the FIFO through a `rd_en` pop interface. The block sits directly after the detector and is clocked by the same `clk`.

## Interface
- `CNT_W`, default 8: width of the saturating match counter.
- `GAP_W`, default 8: width of the gap timer and of each FIFO entry.
- `DEPTH`, default 4: FIFO depth in entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `y_in`  in  1  match pulse from the detector, sampled on each rising edge.
- `clear`  in  1  synchronous clear, same effect as reset.
- `rd_en`  in  1  pop request for the FIFO head.
- `match_cnt`  out  CNT_W  number of matches since reset/clear, saturating.
- `gap_data`  out  GAP_W  FIFO head entry; meaningful only while `gap_valid`=1.
- `gap_valid`  out  1  FIFO not empty.
- `fifo_full`  out  1  FIFO holds DEPTH entries.
- `overflow`  out  1  sticky flag: a gap was dropped because the FIFO was full.

## Operation
- Gap-timer FSM states:
  - IDLE: no match seen since reset/clear.
  - RUN: timer counting.
  - SAT: timer at its maximum, 2^GAP_W−1.
- IDLE: `y_in`=1 loads timer=1, goes to RUN, and pushes nothing. With no match, stay.
- RUN:
  - `y_in`=1 pushes the timer value, reloads timer=1, and stays in RUN.
  - With no match, timer increments. Reaching 2^GAP_W−1 moves to SAT.
- SAT:
  - Timer holds at 2^GAP_W−1.
  - `y_in`=1 pushes 2^GAP_W−1, reloads timer=1, and goes to RUN.
- Gap definition: pulses sampled at edges t1 and t2 give a pushed value of t2−t1, saturated at 2^GAP_W−1. A gap of 1 (back-to-back pulses) must be handled, even though the detector's minimum is 3.
- `match_cnt` increments on every sampled `y_in`=1 in any state and saturates at 2^CNT_W−1.
- FIFO behaviour:
  - Show-ahead: `gap_data` shows the head entry combinationally from storage.
  - `rd_en` with `gap_valid`=1 pops the head. `rd_en` while empty is ignored.
  - Push while full with no valid pop: entry dropped, `overflow` set, contents unchanged.
  - Push and valid pop in the same cycle while full: both occur, occupancy stays DEPTH, no overflow.
  - Push and `rd_en` while empty: push occurs, pop ignored.
- Pointers wrap modulo DEPTH. Occupancy is tracked in a counter of width log2(DEPTH)+1.
- `clear` has priority over `y_in` and `rd_en` in the same cycle; the coincident pulse is lost.
- `overflow` is cleared only by `rst` or `clear`.

## Timing
- `rst` asserted: state IDLE, timer=0, pointers=0, and all outputs 0 (`match_cnt`, `gap_data`, `gap_valid`, `fifo_full`, `overflow`) immediately, without waiting for a clock edge.
- Deassertion of `rst` takes effect at the next rising edge.
- `match_cnt` reflects a pulse one cycle after the edge that sampled it.
- Push latency: a push on edge t raises `gap_valid` and presents `gap_data` after edge t.
- Pop: the head advances after the edge that samples `rd_en`. `gap_valid` falls after that edge if the FIFO became empty.
- `fifo_full` and `overflow` update on the same edge as the causing push.
- `clear` or `rst` mid-operation discards all FIFO entries and the partial gap. The first pulse after clear only starts timing.

## Test plan
- Async reset: with 2 entries buffered, assert `rst` between edges → all outputs 0 before the next edge; after release, `y_in` at one edge → `match_cnt`=1, `gap_valid`=0.
- Basic gaps: `y_in` pulses at edges 10, 13, 20 → `match_cnt`=3; `gap_data`=3 with `gap_valid`=1 after edge 13; pops return 3 then 7, then `gap_valid`=0.
- Saturation (GAP_W=8): pulses 300 cycles apart → pushed 255; the next pulse 4 cycles later pushes 4.
- Overflow (DEPTH=4): 6 pulses 3 cycles apart, no reads → `fifo_full`=1, `overflow`=1, entries 3,3,3,3. Then pop and push on the same edge while full → occupancy stays 4 with no new drop.
- Clear priority: `clear` and `y_in` on the same edge → `match_cnt`=0, FSM IDLE; the next pulse pushes nothing, the one after pushes the correct gap.
- Count saturation (CNT_W=4): 20 pulses → `match_cnt`=15 and holds.
